btb_predictor: RTL
==================

# btb_predictor

Parametrised branch target buffer with per-entry 2-bit saturating direction counters, valid bits, round-robin replacement and a synchronous flush. Sits between fetch (IF) and the branch-resolution stage: IF presents its PC and receives a same-cycle predicted target and direction. The resolution stage writes back the actual outcome of every executed conditional branch.

## Interface
- `PC_W`, 16, width of PCs and targets
- `ENTRIES`, 8, number of BTB entries (≥2)
- `IDX_W`, `$clog2(ENTRIES)`, replacement-pointer width (derived, not overridden)
- `clk` input 1: single clock, all state updates on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `lu_pc` input PC_W: PC of instruction in IF
- `lu_hit` output 1: `lu_pc` matches a valid entry
- `lu_taken` output 1: predict taken (`lu_hit` & counter MSB)
- `lu_target` output PC_W: stored target on hit, 0 on miss
- `upd_valid` input 1: resolved conditional branch this cycle
- `upd_pc` input PC_W: PC of resolved branch
- `upd_target` input PC_W: computed branch target
- `upd_taken` input 1: actual outcome
- `flush` input 1: invalidate all entries at next edge

## Operation
- State: per entry `valid`, `tag` (full PC_W, no truncation), `target`, 2-bit `ctr`; global replacement pointer `ptr` (IDX_W).
- Lookup: compare `lu_pc` against all valid tags. If more than one entry matches, the lowest index wins; this case cannot arise by construction.
- Update on `upd_valid`=1, hit on `upd_pc`:
  - counter steps 00→01→10→11 on taken, reverse on not-taken, saturating at 00 and 11;
  - `target` is overwritten with `upd_target`.
- Update on `upd_valid`=1, miss:
  - allocate entry `ptr`: valid=1, tag=`upd_pc`, target=`upd_target`, ctr=10 if taken else 01;
  - `ptr` ← `ptr`+1, wrapping from ENTRIES-1 to 0 (explicit compare; ENTRIES need not be a power of two);
  - an allocation may evict a valid entry.
- `flush`=1: all valid←0, ctr←00, ptr←0. `flush` takes precedence; a simultaneous update is dropped.
- Reset (any time, including mid-update): same state as flush, applied asynchronously. Outputs: `lu_hit`=0, `lu_taken`=0, `lu_target`=0.

## Timing
- Lookup is combinational with zero latency: outputs depend only on `lu_pc` and current state.
- An update is visible to lookups from the cycle after the edge that commits it, except under `BTB_BYPASS_EN`.
- One update per cycle maximum. There is no backpressure: `upd_valid` is accepted every cycle.
- Flush is visible the cycle after assertion.

## Configuration
- `BTB_BYPASS_EN` defined: when `upd_valid`=1, `flush`=0 and `upd_pc`==`lu_pc` in the same cycle, lookup outputs reflect the post-update entry (hit=1, next counter, `upd_target`), as if already committed. Purely combinational forwarding; register behaviour is unchanged.
- Undefined: lookup sees only pre-edge state; the same-cycle case returns the old entry, or a miss if the entry is not yet allocated.

## Structure
- Package `bpred_pkg`:
  - counter typedef `bp_ctr_t` (2 bits);
  - constants `CTR_SNT`=00, `CTR_WNT`=01, `CTR_WT`=10, `CTR_ST`=11;
  - function `ctr_next(ctr, taken)`;
  - allocation constants `CTR_ALLOC_T`=`CTR_WT`, `CTR_ALLOC_NT`=`CTR_WNT`.
- One sub-module, `btb_entry`: one entry's registers, tag compare, write/flush logic. The top module generates ENTRIES instances and owns `ptr`, hit priority encode and bypass mux.

## Test plan
- Reset: after `rst_n` rises, `lu_pc`=0x0000 → `lu_hit`=0, `lu_taken`=0, `lu_target`=0x0000.
- Allocate: upd 0x0010 / 0x0040 / taken → next cycle, lookup 0x0010 gives hit=1, taken=1, target=0x0040. Then upd 0x0020 not-taken → lookup gives hit=1, taken=0.
- Saturation: on 0x0010 (ctr 10), apply three not-taken updates → ctr 01, 00, 00, taken=0 throughout. Then three taken updates → ctr 01, 10, 11; taken=1 from the second.
- Wrap (ENTRIES=4): allocate 0x0100, 0x0104, 0x0108, 0x010C, 0x0110 → 0x0100 misses, other four hit, ptr=1.
- Flush collision: `flush`=1 with upd 0x0200 in the same cycle → next cycle all lookups miss, including 0x0200. Next allocation lands in entry 0.
- Bypass: upd 0x0300 / 0x0380 / taken with `lu_pc`=0x0300 in the same cycle → with `BTB_BYPASS_EN`, hit=1, taken=1, target=0x0380 that cycle; without, hit=0 that cycle and hit=1 the next.

Source files
------------

// File: rtl/btb_predictor_pkg.sv
// Branch predictor shared types: 2-bit direction counter, its encodings,
// the saturating step function and the counter values used on allocation.
package bpred_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t CTR_SNT = 2'b00;
    localparam bp_ctr_t CTR_WNT = 2'b01;
    localparam bp_ctr_t CTR_WT  = 2'b10;
    localparam bp_ctr_t CTR_ST  = 2'b11;

    // A fresh entry starts weak in the direction it was first seen to go.
    localparam bp_ctr_t CTR_ALLOC_T  = CTR_WT;
    localparam bp_ctr_t CTR_ALLOC_NT = CTR_WNT;

    // Saturating up/down step of a direction counter.
    function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        if (taken)
            nxt = (ctr == CTR_ST)  ? CTR_ST  : bp_ctr_t'(ctr + 2'd1);
        else
            nxt = (ctr == CTR_SNT) ? CTR_SNT : bp_ctr_t'(ctr - 2'd1);
        return nxt;
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// BTB port bundle: fetch-side lookup plus resolution-side update/flush.
// master = fetch/resolution pipeline, slave = the BTB itself.
interface btb_predictor_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] lu_pc;
    logic            lu_hit;
    logic            lu_taken;
    logic [PC_W-1:0] lu_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;
    logic            flush;

    modport master (
        output lu_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
        input  lu_hit, lu_taken, lu_target
    );

    modport slave (
        input  lu_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
        output lu_hit, lu_taken, lu_target
    );
endinterface

// File: rtl/btb_predictor_entry.sv
// One BTB entry: valid/tag/target/counter registers, tag compares for the
// lookup and update PCs, and the allocate / hit-update / flush write paths.
module btb_entry
    import bpred_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            alloc,
    input  logic            upd,
    input  logic [PC_W-1:0] wr_tag,
    input  logic [PC_W-1:0] wr_target,
    input  logic            wr_taken,
    input  logic [PC_W-1:0] lu_pc,
    output logic            lu_match,
    output logic            upd_match,
    output logic [PC_W-1:0] target,
    output bp_ctr_t         ctr
);
    logic            valid;
    logic [PC_W-1:0] tag;

    assign lu_match  = valid && (tag == lu_pc);
    assign upd_match = valid && (tag == wr_tag);

    // Entry state: flush beats any write; allocation reinitialises the whole
    // entry, a hit update only steps the counter and refreshes the target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            ctr    <= CTR_SNT;
        end else if (flush) begin
            valid <= 1'b0;
            ctr   <= CTR_SNT;
        end else if (alloc) begin
            valid  <= 1'b1;
            tag    <= wr_tag;
            target <= wr_target;
            ctr    <= wr_taken ? CTR_ALLOC_T : CTR_ALLOC_NT;
        end else if (upd) begin
            target <= wr_target;
            ctr    <= ctr_next(ctr, wr_taken);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Branch target buffer: ENTRIES fully-associative entries, zero-latency
// lookup, one resolved-branch update per cycle, round-robin allocation.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update on the lookup PC
// straight to the lookup outputs.
module btb_predictor
    import bpred_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    btb_predictor_if.slave        bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0]           lu_match;
    logic [ENTRIES-1:0]           upd_match;
    logic [ENTRIES-1:0]           ent_alloc;
    logic [ENTRIES-1:0]           ent_upd;
    logic [ENTRIES-1:0][PC_W-1:0] ent_target;
    bp_ctr_t [ENTRIES-1:0]        ent_ctr;

    logic             lu_hit_raw;
    logic [IDX_W-1:0] lu_idx;
    logic             upd_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] ptr;
    logic             upd_go;

    logic             out_hit;
    bp_ctr_t          out_ctr;
    logic [PC_W-1:0]  out_target;

    assign upd_go = bus.upd_valid && !bus.flush;

    genvar e;
    generate
        for (e = 0; e < ENTRIES; e++) begin : g_ent
            btb_entry #(.PC_W(PC_W)) u_ent (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (bus.flush),
                .alloc     (ent_alloc[e]),
                .upd       (ent_upd[e]),
                .wr_tag    (bus.upd_pc),
                .wr_target (bus.upd_target),
                .wr_taken  (bus.upd_taken),
                .lu_pc     (bus.lu_pc),
                .lu_match  (lu_match[e]),
                .upd_match (upd_match[e]),
                .target    (ent_target[e]),
                .ctr       (ent_ctr[e])
            );
        end
    endgenerate

    // Lowest-index priority encode for both the lookup and the update PC;
    // scanning downward lets the lowest matching index win.
    always_comb begin
        lu_hit_raw = 1'b0;
        lu_idx     = '0;
        upd_hit    = 1'b0;
        upd_idx    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (lu_match[i]) begin
                lu_hit_raw = 1'b1;
                lu_idx     = IDX_W'(i);
            end
            if (upd_match[i]) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
    end

    // Steer the update: refresh the hitting entry, otherwise allocate at ptr.
    always_comb begin
        ent_alloc = '0;
        ent_upd   = '0;
        if (upd_go) begin
            if (upd_hit)
                ent_upd[upd_idx] = 1'b1;
            else
                ent_alloc[ptr] = 1'b1;
        end
    end

    // Round-robin pointer; explicit wrap so ENTRIES need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (bus.flush)
            ptr <= '0;
        else if (upd_go && !upd_hit)
            ptr <= (ptr == IDX_W'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
    end

    // Lookup outputs from the matching entry, optionally overridden by the
    // post-update view of a same-cycle update to the same PC.
    always_comb begin
        out_hit    = lu_hit_raw;
        out_ctr    = ent_ctr[lu_idx];
        out_target = ent_target[lu_idx];
`ifdef BTB_BYPASS_EN
        if (upd_go && (bus.upd_pc == bus.lu_pc)) begin
            out_hit    = 1'b1;
            out_ctr    = upd_hit ? ctr_next(ent_ctr[upd_idx], bus.upd_taken)
                                 : (bus.upd_taken ? CTR_ALLOC_T : CTR_ALLOC_NT);
            out_target = bus.upd_target;
        end
`endif
        bus.lu_hit    = out_hit;
        bus.lu_taken  = out_hit & out_ctr[1];
        bus.lu_target = out_hit ? out_target : '0;
    end

endmodule
